// File: rtl/pyramid_downsample.sv
// pyramid_downsample: 2x2 decimation of smoothed rows, two kept half-rows packed per output word
module pyramid_downsample #(
  parameter int W    = 8,
  parameter int ROWS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  output logic                ready_i,
  input  logic [15:0][W-1:0]  i,
  output logic                valid_o,
  input  logic                ready_o,
  output logic [15:0][W-1:0]  o,
  output logic                last_o
);
  localparam int RW = $clog2(ROWS);
  typedef enum logic [1:0] {LO, HI, FULL} state_e;
  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [15:0][W-1:0] o_q, o_d;
  logic [7:0][W-1:0]  half;
  logic               last_q, last_d, rdy_q, take;
  for (genvar k = 0; k < 8; k++) begin : g_dec
    assign half[k] = i[2*k];
  end
  assign take    = valid_i && rdy_q;
  assign ready_i = rdy_q;
  assign valid_o = state_q == FULL;
  assign o       = o_q;
  assign last_o  = last_q;
  // next state: row counter with frame wrap, even rows fill LO then HI slot, FULL waits for drain
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    last_d  = last_q;
    row_d   = take ? (row_q == RW'(ROWS-1) ? '0 : row_q + 1'b1) : row_q;
    case (state_q)
      LO: if (take && !row_q[0]) begin
        o_d[7:0] = half;
        state_d  = HI;
      end
      HI: if (take && !row_q[0]) begin
        o_d[15:8] = half;
        last_d    = row_q == RW'(ROWS-2);
        state_d   = FULL;
      end
      default: if (ready_o) begin
        state_d = LO;
        last_d  = 1'b0;
      end
    endcase
  end
  // state registers; ready_i is registered so it stays low throughout reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LO;
      row_q   <= '0;
      o_q     <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      o_q     <= o_d;
      last_q  <= last_d;
      rdy_q   <= state_d != FULL;
    end
  end
`ifndef SYNTHESIS
  logic               hold_q;
  logic [15:0][W-1:0] o_prev_q;
  // remember whether the previous edge saw a stalled word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= 1'b0;
    else hold_q <= valid_o && !ready_o;
  end
  // copy of o from before the previous edge for the stability check
  always_ff @(posedge clk) begin
    o_prev_q <= o;
  end
  // a stalled word must neither vanish nor change
  always @(posedge clk) begin
    if (reset && hold_q && !valid_o) $error("valid_o fell without ready_o");
    if (reset && hold_q && o != o_prev_q) $error("o changed while stalled");
  end
`endif
endmodule

// File: tb/tb_pyramid_downsample.sv
// tb_pyramid_downsample: randomized self-checking bench for the pyramid decimator
module tb_pyramid_downsample;
  typedef logic [15:0][7:0] row_t;
  logic clk, reset, valid_i, ready_i, valid_o, ready_o, last_o;
  row_t din, dout;
  row_t frm[32];
  row_t got_w[$];
  bit   got_l[$];
  int   checks, errors, stalls;
  bit   done;

  pyramid_downsample #(.W(8), .ROWS(16)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_i(ready_i), .i(din),
    .valid_o(valid_o), .ready_o(ready_o), .o(dout), .last_o(last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every output transfer and every stalled input offer
  always @(posedge clk) begin
    if (reset) begin
      if (valid_o && ready_o) begin
        got_w.push_back(dout);
        got_l.push_back(last_o);
      end
      if (valid_i && !ready_i) stalls++;
    end
  end

  // reference: word m = even columns of row 4m (low lanes) and row 4m+2 (high lanes)
  function automatic row_t exp_word(input int base, input int m);
    row_t w;
    for (int k = 0; k < 8; k++) begin
      w[k]   = frm[base + 4*m][2*k];
      w[8+k] = frm[base + 4*m + 2][2*k];
    end
    return w;
  endfunction

  function automatic void fill_basic(input int base);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) frm[base+r][k] = 8'((16*r + k) % 256);
  endfunction

  function automatic void fill_rev(input int base);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) frm[base+r][k] = 8'(255 - k);
  endfunction

  function automatic void fill_rand(input int base);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) frm[base+r][k] = 8'($urandom_range(0, 255));
  endfunction

  function automatic void clear_q();
    got_w.delete();
    got_l.delete();
  endfunction

  // offer one row starting at a negedge; returns at the negedge after acceptance
  task automatic drive_row(input row_t r);
    bit ok;
    ok = 0;
    valid_i = 1'b1;
    din = r;
    for (int c = 0; c < 100 && !ok; c++) begin
      ok = ready_i;
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL row_accept_timeout: ready_i never high in 100 cycles, required 1");
    end
  endtask

  task automatic send_rows(input int base, input int first, input int last_r, input int gap);
    for (int r = first; r <= last_r; r++) begin
      drive_row(frm[base+r]);
      if (gap > 0) begin
        valid_i = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int c = 0; c < 300 && got_w.size() < n; c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    valid_i = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %b, required 0", valid_o); end
    if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last_o: got %b, required 0", last_o); end
    if (dout !== '0) begin errors++; $display("FAIL reset_o: got %h, required 0", dout); end
    if (ready_i !== 1'b0) begin errors++; $display("FAIL reset_ready_i: got %b, required 0", ready_i); end
    if (dut.row_q !== 4'd0) begin errors++; $display("FAIL reset_row_idx: got %0d, required 0", dut.row_q); end
    valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (ready_i !== 1'b1) begin errors++; $display("FAIL release_ready_i: got %b, required 1", ready_i); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL release_valid_o: got %b, required 0", valid_o); end
  endtask

  task automatic test_basic;
    fill_basic(0);
    clear_q();
    ready_o = 1'b1;
    stalls = 0;
    send_rows(0, 0, 15, 0);
    wait_words(4);
    checks++;
    if (got_w.size() != 4) begin errors++; $display("FAIL basic_count: got %0d words, required 4", got_w.size()); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (got_w[m] !== exp_word(0, m) || got_l[m] !== (m == 3))
        begin errors++; $display("FAIL basic_word%0d: got %h last %b, required %h last %b", m, got_w[m], got_l[m], exp_word(0, m), m == 3); end
    end
    checks += 3;
    if (got_w[0][8] !== 8'd32) begin errors++; $display("FAIL basic_w0_lane8: got %0d, required 32", got_w[0][8]); end
    if (got_w[3][0] !== 8'd192) begin errors++; $display("FAIL basic_w3_lane0: got %0d, required 192", got_w[3][0]); end
    if (stalls != 4) begin errors++; $display("FAIL basic_stalls: got %0d, required 4", stalls); end
  endtask

  task automatic test_backpressure;
    fill_rand(0);
    clear_q();
    ready_o = 1'b0;
    send_rows(0, 0, 2, 0);
    valid_i = 1'b1;
    din = frm[3];
    for (int c = 0; c < 10; c++) begin
      checks += 4;
      if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_o c%0d: got %b, required 1", c, valid_o); end
      if (dout !== exp_word(0, 0)) begin errors++; $display("FAIL bp_o c%0d: got %h, required %h", c, dout, exp_word(0, 0)); end
      if (ready_i !== 1'b0) begin errors++; $display("FAIL bp_ready_i c%0d: got %b, required 0", c, ready_i); end
      if (dut.row_q !== 4'd3) begin errors++; $display("FAIL bp_row_idx c%0d: got %0d, required 3", c, dut.row_q); end
      @(negedge clk);
    end
    ready_o = 1'b1;
    send_rows(0, 3, 15, 0);
    wait_words(4);
    checks++;
    if (got_w.size() != 4) begin errors++; $display("FAIL bp_count: got %0d words, required 4", got_w.size()); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (got_w[m] !== exp_word(0, m) || got_l[m] !== (m == 3))
        begin errors++; $display("FAIL bp_word%0d: got %h last %b, required %h last %b", m, got_w[m], got_l[m], exp_word(0, m), m == 3); end
    end
  endtask

  task automatic test_sparse;
    fill_basic(0);
    clear_q();
    ready_o = 1'b1;
    send_rows(0, 0, 15, 2);
    wait_words(4);
    checks++;
    if (got_w.size() != 4) begin errors++; $display("FAIL sparse_count: got %0d words, required 4", got_w.size()); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (got_w[m] !== exp_word(0, m) || got_l[m] !== (m == 3))
        begin errors++; $display("FAIL sparse_word%0d: got %h last %b, required %h last %b", m, got_w[m], got_l[m], exp_word(0, m), m == 3); end
    end
  endtask

  task automatic test_back_to_back;
    fill_basic(0);
    fill_rev(16);
    clear_q();
    done = 1'b0;
    fork
      begin
        send_rows(0, 0, 15, 0);
        send_rows(16, 0, 15, 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          ready_o = 1'($urandom_range(0, 1));
        end
      end
    join
    ready_o = 1'b1;
    wait_words(8);
    checks++;
    if (got_w.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d words, required 8", got_w.size()); end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got_w[m] !== exp_word(0, m) || got_l[m] !== (m % 4 == 3))
        begin errors++; $display("FAIL b2b_word%0d: got %h last %b, required %h last %b", m, got_w[m], got_l[m], exp_word(0, m), m % 4 == 3); end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_w[4][k] !== 8'(255 - 2*k))
        begin errors++; $display("FAIL b2b_w4_lane%0d: got %0d, required %0d", k, got_w[4][k], 255 - 2*k); end
    end
  endtask

  task automatic test_reset_mid;
    fill_rand(0);
    clear_q();
    ready_o = 1'b1;
    send_rows(0, 0, 3, 0);
    ready_o = 1'b0;
    send_rows(0, 4, 6, 0);
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid_o: got %b, required 1", valid_o); end
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid_o: got %b, required 0", valid_o); end
    if (dout !== '0) begin errors++; $display("FAIL rmid_o: got %h, required 0", dout); end
    if (last_o !== 1'b0) begin errors++; $display("FAIL rmid_last_o: got %b, required 0", last_o); end
    if (ready_i !== 1'b0) begin errors++; $display("FAIL rmid_ready_i: got %b, required 0", ready_i); end
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    ready_o = 1'b1;
    fill_rand(0);
    send_rows(0, 0, 15, 0);
    wait_words(4);
    checks++;
    if (got_w.size() != 4) begin errors++; $display("FAIL rmid_count: got %0d words, required 4", got_w.size()); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (got_w[m] !== exp_word(0, m) || got_l[m] !== (m == 3))
        begin errors++; $display("FAIL rmid_word%0d: got %h last %b, required %h last %b", m, got_w[m], got_l[m], exp_word(0, m), m == 3); end
    end
  endtask

  task automatic test_drain;
    fill_rand(0);
    clear_q();
    ready_o = 1'b0;
    send_rows(0, 0, 2, 0);
    valid_i = 1'b1;
    din = frm[3];
    ready_o = 1'b1;
    @(negedge clk);
    checks += 3;
    if (ready_i !== 1'b1) begin errors++; $display("FAIL drain_ready_i: got %b, required 1", ready_i); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid_o: got %b, required 0", valid_o); end
    if (got_w.size() != 1) begin errors++; $display("FAIL drain_consumed: got %0d words, required 1", got_w.size()); end
    drive_row(frm[3]);
    checks++;
    if (dut.row_q !== 4'd4) begin errors++; $display("FAIL drain_row_idx: got %0d, required 4", dut.row_q); end
    send_rows(0, 4, 15, 0);
    wait_words(4);
    checks++;
    if (got_w.size() != 4) begin errors++; $display("FAIL drain_count: got %0d words, required 4", got_w.size()); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (got_w[m] !== exp_word(0, m) || got_l[m] !== (m == 3))
        begin errors++; $display("FAIL drain_word%0d: got %h last %b, required %h last %b", m, got_w[m], got_l[m], exp_word(0, m), m == 3); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stalls = 0;
    reset = 1'b0;
    valid_i = 1'b0;
    ready_o = 1'b1;
    din = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_sparse;
    test_back_to_back;
    test_reset_mid;
    test_drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pyramid_downsample.md
Name: pyramid_downsample

Overview:
- Downstream neighbour of the Conv2D smoothing stage in the Gaussian pyramid datapath.
- Consumes 16-pixel rows of the smoothed 16x16 tile over ready-valid and decimates by 2 in both dimensions: odd rows and odd columns are dropped.
- Packs two kept half-rows (8 pixels each) into one 16-pixel word and emits it over ready-valid to the next pyramid level.
- Each input frame of ROWS rows produces ROWS/4 output words.

Parameters:
- W, 8, pixel width in bits.
- ROWS, 16, rows per frame. Must be a multiple of 4 and no greater than 256.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset. State clears immediately when low; release is synchronous to clk.
- valid_i  input  1  upstream row valid.
- ready_i  output  1  block can accept a row.
- i  input  16xW  input row; lane k = column k.
- valid_o  output  1  packed word valid.
- ready_o  input  1  downstream ready.
- o  output  16xW  packed word; lanes 0..7 = row 4m, lanes 8..15 = row 4m+2.
- last_o  output  1  high with valid_o on the final word of a frame (m = ROWS/4-1).

Behaviour:
- Transfers: an input transfer occurs on a rising edge with valid_i & ready_i. An output transfer occurs with valid_o & ready_o.
- Reset values (while reset low): valid_o=0, last_o=0, o=0, ready_i=0, row_idx=0, state=LO.
- Row counter: row_idx is a clog2(ROWS)-bit counter. It increments on every input transfer and wraps ROWS-1 -> 0.
  - Row parity: row_idx[0].
  - Slot select: row_idx[1] (0 = LO slot, 1 = HI slot).
- Column decimation: the kept half-row is pixels i[0], i[2], ..., i[14], mapped in order to slot lanes 0..7.
- States: LO (collecting row 4m), HI (collecting row 4m+2), FULL (word held).
  - LO:
    - Transfer of an odd row: discarded, stay in LO.
    - Transfer of an even row: decimated pixels written to o[0..7], go to HI.
  - HI:
    - Transfer of an odd row: discarded, stay in HI.
    - Transfer of an even row: decimated pixels written to o[8..15]. last_o is set if row_idx == ROWS-2. Go to FULL.
  - FULL:
    - valid_o=1, and o and last_o are held stable.
    - On an output transfer: go to LO and clear last_o. o keeps stale data; it is not cleared.
- ready_i = (state != FULL). Registered-state only; there is no combinational path from ready_o. Odd rows also stall while FULL.
- valid_o = (state == FULL), registered.
- Latency: valid_o rises on the edge that accepts row 4m+2, i.e. visible the following cycle.
- Throughput: one output word per 4 accepted rows, plus one stall cycle per output word. An upstream offering a row every cycle sees ready_i low for exactly 1 cycle per word when ready_o=1.
- Protocol checks (simulation only, excluded under SYNTHESIS):
  - $error if valid_o falls without ready_o.
  - $error if o changes while valid_o & !ready_o.
- Boundary conditions:
  - Downstream back-pressure: the block stays in FULL indefinitely. ready_i stays 0 and row_idx does not advance.
  - Frame wrap: after row ROWS-1, row_idx returns to 0 and the next even row lands in LO.
  - valid_i held with ready_i=0: no transfer and no counter change.
  - Reset mid-frame or mid-FULL: the pending word is dropped. After release the block restarts at row 0 in LO, with last_o=0 and valid_o=0.
- Implementation: all state is in always_ff with asynchronous negedge reset. Pixels pass through unmodified; there is no arithmetic on them.

Test Plan:
- Basic frame: ROWS=16, row r has pixel k = 16r+k (mod 256), ready_o=1, valid_i continuous -> 4 words.
  - Word 0: lanes 0..7 = 0,2,...,14; lanes 8..15 = 32,34,...,46.
  - Word 3: lanes 0..7 = 192,...,206; lanes 8..15 = 224,...,238; last_o=1 only on word 3.
- Back-pressure: hold ready_o=0 for 10 cycles after word 0 becomes valid.
  - valid_o stays 1 and o is unchanged.
  - ready_i=0 for all 10 cycles and row_idx frozen at 3.
  - After ready_o=1, word 1 matches the expected value.
- Sparse input: valid_i toggles every third cycle -> output identical to the basic-frame test. Odd rows never reach o.
- Two back-to-back frames: second frame has pixel k = 255-k in every row.
  - Word 4 lanes 0..7 = 255,253,...,241.
  - last_o asserted on words 3 and 7 only.
- Reset mid-operation: assert reset low while in FULL after 6 rows.
  - valid_o drops immediately (asynchronously) and o=0.
  - After release, a fresh 16-row frame yields exactly 4 correct words.
- Same-cycle drain: in FULL with ready_o=1 and valid_i=1.
  - Word consumed on that edge; next cycle ready_i=1.
  - The offered row is accepted one cycle later with no data loss.
